alu_serial: RTL

Parametrised, multi-cycle successor to the 32-bit combinational ALU. It processes operands SLICE bits per cycle through a carry chain registered between slices, trading latency for area. It keeps the same command set and the same flags: result, carryout, zero, overflow. A valid/ready handshake on both input and output lets it sit between a sequencer and a register-file writeback stage.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_slice.sv | 42 ++++
 rtl/alu_serial.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: command codes, FSM encoding and command helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package alu_pkg;

   localparam logic [2:0] CMD_ADD  = 3'd0;
   localparam logic [2:0] CMD_SUB  = 3'd1;
   localparam logic [2:0] CMD_XOR  = 3'd2;
   localparam logic [2:0] CMD_SLT  = 3'd3;
   localparam logic [2:0] CMD_AND  = 3'd4;
   localparam logic [2:0] CMD_NAND = 3'd5;
   localparam logic [2:0] CMD_NOR  = 3'd6;
   localparam logic [2:0] CMD_OR   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Commands that run through the carry chain (SLT is a subtract underneath).
   function automatic logic is_arith(input logic [2:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SLT);
   endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE-bit step of the serial ALU: adder/subtractor or bitwise op on one slice.
// Purely combinational, zero latency; no flow control.
module alu_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   input  logic [2:0]       command,
   output logic [SLICE-1:0] result,
   output logic             cout,
   output logic             cmsb
);
   import alu_pkg::*;

   logic [SLICE-1:0] b_eff;
   logic [SLICE:0]   sum;

   always_comb begin
      b_eff  = (command == CMD_ADD) ? b : ~b;
      sum    = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
      result = '0;
      cout   = 1'b0;
      cmsb   = 1'b0;
      if (is_arith(command)) begin
         result = sum[SLICE-1:0];
         cout   = sum[SLICE];
         // Carry into the top bit recovered from its sum bit and its two addend bits.
         cmsb   = sum[SLICE-1] ^ a[SLICE-1] ^ b_eff[SLICE-1];
      end else begin
         case (command)
            CMD_XOR:  result = a ^ b;
            CMD_AND:  result = a & b;
            CMD_NAND: result = ~(a & b);
            CMD_NOR:  result = ~(a | b);
            CMD_OR:   result = a | b;
            default:  result = '0;
         endcase
      end
   end

endmodule

// File: rtl/alu_serial.sv
// Serial ALU: WIDTH-bit operation done SLICE bits per cycle, latency N=WIDTH/SLICE cycles after accept.
// Valid/ready both sides; one op in flight, outputs held while out_ready is low.
module alu_serial #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       command,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             zero,
   output logic             overflow
);
   import alu_pkg::*;

   localparam int N     = WIDTH / SLICE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]       cmd_q, cmd_d;
   logic             carry_q, carry_d;
   logic             carryout_q, carryout_d;
   logic             zero_q, zero_d;
   logic             overflow_q, overflow_d;

   logic [SLICE-1:0] sl_res;
   logic             sl_cout, sl_cmsb;
   logic [WIDTH-1:0] sl_ext, res_shift;

   alu_slice #(.SLICE(SLICE)) u_slice (
      .a       (a_q[SLICE-1:0]),
      .b       (b_q[SLICE-1:0]),
      .cin     (carry_q),
      .command (cmd_q),
      .result  (sl_res),
      .cout    (sl_cout),
      .cmsb    (sl_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)       state_d = ST_BUSY;
         ST_BUSY: if (cnt_q == LAST)  state_d = ST_DONE;
         ST_DONE: if (out_ready)      state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      cmd_d      = cmd_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      res_d      = res_q;
      carryout_d = carryout_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;

      sl_ext            = '0;
      sl_ext[SLICE-1:0] = sl_res;
      // Result fills from the top: after N shifts slice 0 sits at bit 0.
      res_shift = (res_q >> SLICE) | (sl_ext << (WIDTH - SLICE));

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               cmd_d   = command;
               cnt_d   = '0;
               carry_d = (command == CMD_SUB) || (command == CMD_SLT);
            end
         end
         ST_BUSY: begin
            a_d     = a_q >> SLICE;
            b_d     = b_q >> SLICE;
            carry_d = sl_cout;
            res_d   = res_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               cnt_d      = '0;
               carry_d    = 1'b0;
               carryout_d = 1'b0;
               overflow_d = 1'b0;
               if ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)) begin
                  carryout_d = sl_cout;
                  overflow_d = sl_cout ^ sl_cmsb;
               end else if (cmd_q == CMD_SLT) begin
                  // Sign of difference corrected by overflow gives the true signed compare.
                  res_d    = '0;
                  res_d[0] = sl_res[SLICE-1] ^ sl_cout ^ sl_cmsb;
               end
               zero_d = (res_d == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         cmd_q      <= CMD_ADD;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         res_q      <= '0;
         carryout_q <= 1'b0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         cmd_q      <= cmd_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         res_q      <= res_d;
         carryout_q <= carryout_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
      end
   end

   assign result   = res_q;
   assign carryout = carryout_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;

endmodule
